// File: rtl/injection_scheduler.sv
// ---------------------------------------------------------------------------
// injection_scheduler
//
// Sequences packet launches into a single per-router packet injector.
// Requests from a traffic source are queued in a small FIFO. Each launch
// takes the FIFO head and gives it the next sequential packet ID. The block
// then waits for the injector's completion pulse before it launches again.
// A programmable gap separates packets. A watchdog abandons packets that
// never finish.
//
// Handshake: a request transfers on any rising edge where
// req_valid && req_ready. req_ready depends only on FIFO fullness, never on
// req_valid or on a pop in the same cycle. A request whose amount is
// illegal is still consumed, but it is dropped and err_reject is flagged.
//
// Ports
//   CLK              in   clock, all logic on the rising edge
//   RST              in   asynchronous, active-low reset
//   enable           in   launches allowed while high
//   req_valid        in   request present
//   req_ready        out  FIFO can accept (not full)
//   req_dst          in   packet destination
//   req_amount       in   body-flit count
//   gap_cycles       in   idle cycles between finished and next launch
//   inj_start        out  one-cycle launch pulse
//   inj_destination  out  destination, held from launch until finished/abort
//   inj_id           out  packet ID, held likewise
//   inj_flit_amount  out  flit amount, held likewise
//   inj_finished     in   injector completion pulse (ignored outside WAIT)
//   busy             out  high while launching, waiting or in the gap
//   pkt_count        out  packets completed, saturating at 0xFFFF
//   err_reject       out  one-cycle pulse, illegal amount dropped
//   err_timeout      out  one-cycle pulse, watchdog abort
//   dbg_state        out  current FSM state (IDLE=0 LAUNCH=1 WAIT=2 GAP=3)
// ---------------------------------------------------------------------------
module injection_scheduler #(
    parameter int P_DST_WIDTH  = 4,
    parameter int P_ID_WIDTH   = 8,
    parameter int P_AMT_WIDTH  = 4,
    parameter int P_MAX_AMOUNT = 5,
    parameter int P_FIFO_DEPTH = 4,   // power of two, at least 2
    parameter int P_TIMEOUT    = 255
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   enable,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [P_DST_WIDTH-1:0] req_dst,
    input  logic [P_AMT_WIDTH-1:0] req_amount,
    input  logic [7:0]             gap_cycles,
    output logic                   inj_start,
    output logic [P_DST_WIDTH-1:0] inj_destination,
    output logic [P_ID_WIDTH-1:0]  inj_id,
    output logic [P_AMT_WIDTH-1:0] inj_flit_amount,
    input  logic                   inj_finished,
    output logic                   busy,
    output logic [15:0]            pkt_count,
    output logic                   err_reject,
    output logic                   err_timeout,
    output logic [1:0]             dbg_state
);

    localparam int AW  = $clog2(P_FIFO_DEPTH);
    localparam int PW  = AW + 1;                  // extra wrap bit
    localparam int WDW = $clog2(P_TIMEOUT + 1);
    localparam int EW  = P_DST_WIDTH + P_AMT_WIDTH;

    localparam logic [P_AMT_WIDTH-1:0] MAX_AMT = P_AMT_WIDTH'(P_MAX_AMOUNT);
    // The watchdog is cleared in LAUNCH. It therefore holds k-1 during the
    // k-th WAIT cycle. The abort fires in the P_TIMEOUT-th WAIT cycle.
    localparam logic [WDW-1:0] WD_LAST = WDW'(P_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t                  state;
    logic [P_ID_WIDTH-1:0]   next_id;
    logic [WDW-1:0]          wdog;
    logic [7:0]              gap_cnt;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0]           mem [P_FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic                    full;
    logic                    empty;
    logic                    accept;
    logic                    amount_ok;
    logic                    push;
    logic                    pop;
    logic [EW-1:0]           head;

    // Same index with a different wrap bit means the writer has lapped the
    // reader. In that case the FIFO is full.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign req_ready = !full;
    assign accept    = req_valid && !full;
    assign amount_ok = (req_amount <= MAX_AMT);
    assign push      = accept && amount_ok;
    assign pop       = (state == S_IDLE) && enable && !empty;
    assign head      = mem[rd_ptr[AW-1:0]];

    // Storage needs no reset. Only the pointers define which entries are valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {req_dst, req_amount};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            err_reject <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            err_reject <= accept && !amount_ok;
        end
    end

    // ------------------------------------------------------------------
    // Launch sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state           <= S_IDLE;
            next_id         <= '0;
            wdog            <= '0;
            gap_cnt         <= '0;
            inj_start       <= 1'b0;
            inj_destination <= '0;
            inj_id          <= '0;
            inj_flit_amount <= '0;
            busy            <= 1'b0;
            pkt_count       <= '0;
            err_timeout     <= 1'b0;
        end else begin
            inj_start   <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        inj_destination <= head[EW-1:P_AMT_WIDTH];
                        inj_flit_amount <= head[P_AMT_WIDTH-1:0];
                        inj_id          <= next_id;
                        inj_start       <= 1'b1;  // high for the LAUNCH cycle only
                        busy            <= 1'b1;
                        state           <= S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
                    wdog  <= '0;
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    wdog <= wdog + 1'b1;
                    // Finished takes priority over a coincident timeout.
                    if (inj_finished) begin
                        if (pkt_count != 16'hFFFF) begin
                            pkt_count <= pkt_count + 1'b1;
                        end
                        next_id <= next_id + 1'b1;
                        if (gap_cycles != 8'd0) begin
                            gap_cnt <= gap_cycles;
                            state   <= S_GAP;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else if (wdog == WD_LAST) begin
                        // An aborted packet still uses up its ID.
                        err_timeout <= 1'b1;
                        next_id     <= next_id + 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                S_GAP: begin
                    // gap_cnt was loaded with a non-zero value on entry. GAP
                    // therefore lasts exactly that many cycles.
                    if (gap_cnt == 8'd1) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_injection_scheduler.sv
// ---------------------------------------------------------------------------
// tb_injection_scheduler
//
// This bench checks the injection scheduler against a timeline model. The
// model works from the behavioural rules, not from the RTL structure:
//   * exp_q holds the accepted {dst, amount} requests in arrival order.
//   * A packet launched in cycle s accepts a finish in cycles s+1..s+255.
//     The 255th cycle without a finish aborts the packet.
//   * A packet that ends in cycle f lets the next pop happen at cycle
//     f+1+gap. The scheduler is busy from the launch until that cycle.
// Inputs change just after each falling edge. Outputs are compared there
// too, half a cycle away from the active edge.
// ---------------------------------------------------------------------------
module tb_injection_scheduler;

    localparam int DEPTH   = 4;
    localparam int MAX_AMT = 5;
    localparam int TIMEOUT = 255;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_dst = '0;
    logic [3:0]  req_amount = '0;
    logic [7:0]  gap_cycles = '0;
    logic        inj_start;
    logic [3:0]  inj_destination;
    logic [7:0]  inj_id;
    logic [3:0]  inj_flit_amount;
    logic        inj_finished = 1'b0;
    logic        busy;
    logic [15:0] pkt_count;
    logic        err_reject;
    logic        err_timeout;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    injection_scheduler dut (
        .CLK             (clk),
        .RST             (rst_n),
        .enable          (enable),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_dst         (req_dst),
        .req_amount      (req_amount),
        .gap_cycles      (gap_cycles),
        .inj_start       (inj_start),
        .inj_destination (inj_destination),
        .inj_id          (inj_id),
        .inj_flit_amount (inj_flit_amount),
        .inj_finished    (inj_finished),
        .busy            (busy),
        .pkt_count       (pkt_count),
        .err_reject      (err_reject),
        .err_timeout     (err_timeout),
        .dbg_state       (dbg_state)
    );

    // ---------------- reference model state ----------------
    logic [7:0] exp_q[$];        // {dst, amount} of queued requests
    int         t;               // cycle index
    int         m_id;
    int         m_cnt;
    bit         m_active;        // a packet is launched and not yet ended
    int         m_start;         // cycle in which inj_start was high
    int         m_ready_at;      // first cycle in which a pop may happen
    logic       e_start, e_rej, e_tmo, e_busy;
    logic [3:0] e_dst, e_amt;
    logic [7:0] e_id;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, t);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_id       = 0;
        m_cnt      = 0;
        m_active   = 1'b0;
        m_start    = 0;
        m_ready_at = t;
        e_start    = 1'b0;
        e_rej      = 1'b0;
        e_tmo      = 1'b0;
        e_busy     = 1'b0;
        e_dst      = '0;
        e_amt      = '0;
        e_id       = '0;
    endtask

    // Compares the outputs of the current cycle. Then advances the model
    // with the inputs applied in this cycle, and moves on to the next
    // falling edge.
    task automatic step();
        logic [7:0] head;
        bit         accept;
        bit         pop;

        check_eq("req_ready",       req_ready, 32'(exp_q.size() < DEPTH));
        check_eq("inj_start",       inj_start, e_start);
        check_eq("busy",            busy, e_busy);
        check_eq("err_reject",      err_reject, e_rej);
        check_eq("err_timeout",     err_timeout, e_tmo);
        check_eq("pkt_count",       pkt_count, m_cnt);
        check_eq("inj_id",          inj_id, e_id);
        check_eq("inj_destination", inj_destination, e_dst);
        check_eq("inj_flit_amount", inj_flit_amount, e_amt);

        accept  = req_valid && (exp_q.size() < DEPTH);
        pop     = !m_active && (t >= m_ready_at) && enable && (exp_q.size() > 0);
        e_start = 1'b0;
        e_rej   = 1'b0;
        e_tmo   = 1'b0;

        if (pop) begin
            head     = exp_q.pop_front();
            e_dst    = head[7:4];
            e_amt    = head[3:0];
            e_id     = 8'(m_id);
            e_start  = 1'b1;
            m_active = 1'b1;
            m_start  = t + 1;
        end else if (m_active && (t > m_start)) begin
            if (inj_finished) begin
                if (m_cnt < 16'hFFFF) m_cnt++;
                m_id       = (m_id + 1) % 256;
                m_active   = 1'b0;
                m_ready_at = t + 1 + int'(gap_cycles);
            end else if (t - m_start == TIMEOUT) begin
                e_tmo      = 1'b1;
                m_id       = (m_id + 1) % 256;
                m_active   = 1'b0;
                m_ready_at = t + 1;
            end
        end

        if (accept) begin
            if (int'(req_amount) > MAX_AMT) e_rej = 1'b1;
            else exp_q.push_back({req_dst, req_amount});
        end

        e_busy = m_active || (t + 1 < m_ready_at);

        @(negedge clk);
        t++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_one(input logic [3:0] dst, input logic [3:0] amt);
        req_valid  = 1'b1;
        req_dst    = dst;
        req_amount = amt;
        step();
        req_valid  = 1'b0;
    endtask

    // Random stimulus. Probabilities are given in percent. If fin_at > 0,
    // finished is driven exactly fin_at cycles after each launch.
    task automatic run(input int cycles, input int p_valid, input int p_fin,
                       input int p_en, input int amt_max, input int gap_lo,
                       input int gap_hi, input int fin_at);
        for (int i = 0; i < cycles; i++) begin
            req_valid  = ($urandom_range(99) < p_valid);
            req_dst    = 4'($urandom_range(15));
            req_amount = 4'($urandom_range(amt_max));
            enable     = ($urandom_range(99) < p_en);
            gap_cycles = 8'($urandom_range(gap_hi, gap_lo));
            if (fin_at > 0) inj_finished = m_active && (t - m_start == fin_at);
            else            inj_finished = ($urandom_range(99) < p_fin);
            step();
        end
        req_valid    = 1'b0;
        inj_finished = 1'b0;
    endtask

    task automatic async_reset();
        req_valid    = 1'b0;
        inj_finished = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_inj_start",   inj_start, 0);
        check_eq("rst_inj_dst",     inj_destination, 0);
        check_eq("rst_inj_id",      inj_id, 0);
        check_eq("rst_inj_amount",  inj_flit_amount, 0);
        check_eq("rst_busy",        busy, 0);
        check_eq("rst_pkt_count",   pkt_count, 0);
        check_eq("rst_err_timeout", err_timeout, 0);
        check_eq("rst_err_reject",  err_reject, 0);
        check_eq("rst_req_ready",   req_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        t = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Single packet, dst 3 amt 2, no gap, finish 6 cycles after launch.
        enable = 1'b1;
        gap_cycles = 8'd0;
        push_one(4'd3, 4'd2);
        run(12, 0, 0, 100, 0, 0, 0, 6);
        push_one(4'd9, 4'd1);
        run(8, 0, 0, 100, 0, 0, 0, 1);

        // Fill while disabled (fifth is refused), then drain with pressure.
        enable = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_dst    = 4'(i + 1);
            req_amount = 4'(i);
            step();
        end
        run(40, 100, 0, 100, 5, 0, 0, 2);
        run(40, 0, 0, 100, 0, 0, 0, 2);

        // Illegal amount is dropped; the maximum legal amount is accepted.
        enable = 1'b1;
        push_one(4'd7, 4'd6);
        run(3, 0, 0, 100, 0, 0, 0, 2);
        push_one(4'd7, 4'd5);
        run(8, 0, 0, 100, 0, 0, 0, 2);

        // Gap of 4 cycles between two queued packets.
        enable = 1'b0;
        push_one(4'd1, 4'd1);
        push_one(4'd2, 4'd2);
        run(30, 0, 0, 100, 0, 4, 4, 3);

        // Two stalled packets time out; the next one arrives on the last cycle.
        enable = 1'b1;
        push_one(4'd4, 4'd3);
        push_one(4'd5, 4'd4);
        run(600, 0, 0, 100, 0, 0, 0, 0);
        push_one(4'd6, 4'd0);
        run(300, 0, 0, 100, 0, 0, 0, TIMEOUT);

        // Asynchronous reset while in WAIT with two entries still queued.
        enable = 1'b1;
        push_one(4'd8, 4'd1);
        push_one(4'd9, 4'd2);
        push_one(4'd10, 4'd3);
        run(4, 0, 0, 100, 0, 0, 0, 0);
        async_reset();
        run(10, 0, 0, 100, 0, 0, 0, 0);

        // Random soak: illegal amounts, stray finishes, varying gap and enable.
        run(3000, 40, 20, 80, 7, 0, 3, 0);
        run(100, 0, 30, 100, 0, 0, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
